// File: rtl/out_mem_drain.sv
`default_nettype none
// ============================================================================
//  Module      : out_mem_drain
//  Description : Read-side drain engine for the banked output memory. On a
//                start command it reads a contiguous range of rows (same
//                address in every bank) and streams them downstream over a
//                valid/ready link, one row per cycle, lossless under
//                backpressure through a 2-entry row buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module out_mem_drain #(
    parameter int NUM_BANK   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [CNT_WIDTH-1:0]           num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_BANK-1:0]            mem_rd_en,
    output logic [NUM_BANK*ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [NUM_BANK*DATA_WIDTH-1:0] mem_rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_BANK*DATA_WIDTH-1:0] out_data,
    output logic                           out_last
);

    localparam int                   c_ROW_W   = NUM_BANK * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    // Command context
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   r_issued;
    logic [CNT_WIDTH-1:0]   r_popped;
    logic                   r_zero_done;

    // Read return tracking: one row may be in flight from the banks
    logic                   r_inflight;
    logic                   r_infl_last;

    // Two-entry row buffer
    logic [c_ROW_W-1:0]     r_buf_data [2];
    logic                   r_buf_last [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;

    logic                   w_pop;
    logic                   w_push;
    logic [2:0]             w_occ_after;
    logic                   w_room;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_drain_done;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;

    assign w_pop    = out_valid & out_ready;
    assign w_push   = r_inflight;

    // Rows that will be buffered or in flight once this cycle's pop is
    // taken; a new read may only go out if that leaves a free slot.
    assign w_occ_after = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room      = (w_occ_after < 3'd2);

    assign w_issue  = (r_state == ST_ISSUE) && (r_issued != r_num) && w_room;
    assign w_accept = (r_state == ST_IDLE) && start && (num_rows != '0);

    assign w_rd_addr   = w_issue ? (r_base + ADDR_WIDTH'(r_issued)) : '0;
    assign mem_rd_en   = {NUM_BANK{w_issue}};
    assign mem_rd_addr = {NUM_BANK{w_rd_addr}};

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_zero_done | w_drain_done;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_buf_data[r_rptr];
    assign out_last  = out_valid & r_buf_last[r_rptr];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and end-of-command detection
    always_comb begin
        w_next_state = r_state;
        w_drain_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_issued == r_num) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_popped == r_num) begin
                    w_drain_done = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Command latch, issue/pop counters and the zero-length done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base      <= '0;
            r_num       <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= (r_state == ST_IDLE) && start && (num_rows == '0);
            if (w_accept) begin
                r_base   <= base_addr;
                r_num    <= num_rows;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + c_CNT_ONE;
                end
                if (w_pop) begin
                    r_popped <= r_popped + c_CNT_ONE;
                end
            end
        end
    end

    // In-flight flag: bank data for an issued row appears one cycle later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_inflight  <= w_issue;
            r_infl_last <= w_issue && (r_issued == (r_num - c_CNT_ONE));
        end
    end

    // Row buffer: push returning bank data, pop on handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last[0] <= 1'b0;
            r_buf_last[1] <= 1'b0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wptr] <= mem_rd_data;
                r_buf_last[r_wptr] <= r_infl_last;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_mem_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_out_mem_drain
//  Description : Self-checking bench for out_mem_drain. Table of drain
//                commands plus hand-written reset-mid-command sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_out_mem_drain;

    localparam int NB = 16;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int CW = 16;
    localparam int RW = NB * DW;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [CW-1:0]  num_rows;
    logic           busy;
    logic           done;
    logic [NB-1:0]  mem_rd_en;
    logic [NB*AW-1:0] mem_rd_addr;
    logic [RW-1:0]  mem_rd_data;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  out_data;
    logic           out_last;

    int total = 0;
    int bad   = 0;
    int quiet;

    always #5 clk = ~clk;

    out_mem_drain #(
        .NUM_BANK   (NB),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    // Bank contents: bank b, address a holds {a[7:0], b[7:0]}
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a, input int b);
        return {16'h0000, a[7:0], 8'(b)};
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int b = 0; b < NB; b++) begin
            r[b*DW +: DW] = word_of(a, b);
        end
        return r;
    endfunction

    // Memory model with one-cycle read latency; garbage when not enabled
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            mem_rd_data[b*DW +: DW] <= mem_rd_en[b] ? word_of(mem_rd_addr[b*AW +: AW], b)
                                                    : 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] num;
        logic [31:0]   rdy;       // out_ready for cycle k is rdy[k%32]
        int            exp_done;  // expected done cycle, <=0 means don't care
        int            inj;       // cycle of a second (ignored) start, 0 = none
    } vec_t;

    vec_t vecs [8];

    // Issue one command and check it cycle by cycle until done has passed
    task automatic run_cmd(input vec_t v);
        int            iss;
        int            pops;
        int            rows;
        int            dones;
        int            done_cyc;
        int            occ;
        logic          pop_now;
        logic          prev_stall;
        logic [RW-1:0] prev_data;
        logic [AW-1:0] exp_a;
        iss = 0; pops = 0; rows = 0; dones = 0; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        num_rows  = v.num;
        out_ready = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == v.inj) begin
                start     = 1'b1;
                base_addr = v.base ^ 16'h0A00;
                num_rows  = 16'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = v.rdy[cyc % 32];
            #1;
            pop_now = out_valid & out_ready;
            chk("busy", busy, (v.num != 0) && (dones == 0));
            chk("rd_en_uniform", mem_rd_en, {NB{mem_rd_en[0]}});
            chk("rd_addr_uniform", mem_rd_addr, {NB{mem_rd_addr[AW-1:0]}});
            if (mem_rd_en[0]) begin
                occ = iss - pops;
                chk("rd_en_room", ((iss < int'(v.num)) && ((occ - int'(pop_now)) < 2)), 1'b1);
                exp_a = v.base + AW'(iss);
                chk("rd_addr", mem_rd_addr[AW-1:0], exp_a);
                iss++;
            end
            if (out_valid && rows < int'(v.num)) begin
                chk("row_last", out_last, (rows == int'(v.num) - 1));
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (pop_now) begin
                if (rows < int'(v.num)) begin
                    exp_a = v.base + AW'(rows);
                    chk("row_data", out_data, row_of(exp_a));
                    if (v.base == 16'h0010 && rows == 2) begin
                        chk("row2_bank5", out_data[5*DW +: DW], 32'h0000_1205);
                    end
                end else begin
                    chk("extra_row", rows, v.num);
                end
                rows++;
                pops++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk("rows_total", rows, v.num);
        chk("issues_total", iss, v.num);
        chk("done_count", dones, 1);
        if (v.exp_done > 0) begin
            chk("done_cycle", done_cyc, v.exp_done);
        end
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        out_ready = 1'b0;

        vecs[0] = '{base: 16'h0010, num: 16'd4, rdy: 32'hFFFF_FFFF, exp_done: 7, inj: 0};
        vecs[1] = '{base: 16'h0100, num: 16'd8, rdy: 32'hA5A5_6969, exp_done: 0, inj: 0};
        vecs[2] = '{base: 16'h0033, num: 16'd0, rdy: 32'hFFFF_FFFF, exp_done: 1, inj: 0};
        vecs[3] = '{base: 16'hFFFE, num: 16'd4, rdy: 32'hFFFF_FFFF, exp_done: 7, inj: 0};
        vecs[4] = '{base: 16'hFFFF, num: 16'd3, rdy: 32'hFFFF_FFFF, exp_done: 6, inj: 0};
        vecs[5] = '{base: 16'h0040, num: 16'd1, rdy: 32'hFFFF_FFFF, exp_done: 4, inj: 0};
        vecs[6] = '{base: 16'h0200, num: 16'd5, rdy: 32'h5555_5555, exp_done: 0, inj: 0};
        vecs[7] = '{base: 16'h0300, num: 16'd6, rdy: 32'hFFFF_FFFF, exp_done: 9, inj: 3};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_rd_en", mem_rd_en, '0);
        chk("rst_rd_addr", mem_rd_addr, '0);
        chk("rst_data", out_data, '0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // Asynchronous reset after the second row of eight has handshaken
        @(negedge clk);
        start     = 1'b1;
        base_addr = 16'h0700;
        num_rows  = 16'd8;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_row1", out_data, row_of(16'h0701));
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_rd_en", mem_rd_en, '0);
        chk("mid_rst_rd_addr", mem_rd_addr, '0);
        chk("mid_rst_data", out_data, '0);
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || out_valid || busy || mem_rd_en[0]) quiet++;
        end
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done || out_valid || busy || mem_rd_en[0]) quiet++;
        end
        chk("post_rst_quiet", quiet, 0);
        run_cmd('{base: 16'h0020, num: 16'd3, rdy: 32'hFFFF_FFFF, exp_done: 6, inj: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
